// File: rtl/frame_ingress_arbiter_pkg.sv
// Shared definitions for the frame ingress arbiter: header word field offsets,
// length counter width and the FSM state type.
package frame_ingress_arbiter_pkg;

  localparam int ERR_BIT   = 15;
  localparam int LEN_MSB   = 14;
  localparam int LEN_LSB   = 4;
  localparam int PORT_MSB  = 3;
  localparam int HDR_BYTES = 14;
  localparam int LEN_W     = 11;

  localparam logic [LEN_W-1:0] LEN_SAT = '1;

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } st_e;

endpackage

// File: rtl/frame_ingress_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after
// the pointer, wrapping around; o_valid is high when any request is present.
module rr_arbiter #(
  parameter  int PORT_NUM = 4,
  localparam int PW       = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1
) (
  input  logic [PORT_NUM-1:0] i_req,
  input  logic [PW-1:0]       i_ptr,
  output logic [PORT_NUM-1:0] o_gnt,
  output logic                o_valid
);

  // Walk from the farthest offset down so the nearest requester wins last.
  always_comb begin
    o_gnt   = '0;
    o_valid = |i_req;
    for (int k = PORT_NUM - 1; k >= 0; k--) begin
      if (i_req[(int'(i_ptr) + k) % PORT_NUM]) begin
        o_gnt = '0;
        o_gnt[(int'(i_ptr) + k) % PORT_NUM] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/frame_ingress_arbiter.sv
// Round-robin ingress arbiter: moves whole frames from per-port RX FIFOs into the
// shared body FIFO and emits one header word per frame. PORT_STATS_EN adds counters.
module frame_ingress_arbiter
  import frame_ingress_arbiter_pkg::*;
#(
  parameter int PORT_NUM      = 4,
  parameter int HEADER_DWIDTH = 128,
  parameter int MIN_LEN       = 60,
  parameter int MAX_LEN       = 1518
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [PORT_NUM*8-1:0]    in_dout,
  input  logic [PORT_NUM-1:0]      in_empty,
  input  logic [PORT_NUM-1:0]      in_eod,
  input  logic [PORT_NUM-1:0]      in_frame_exist,
  output logic [PORT_NUM-1:0]      in_rden,
  output logic [HEADER_DWIDTH-1:0] h_fifo_din,
  output logic                     h_fifo_wren,
  input  logic                     h_fifo_full,
  output logic [7:0]               b_fifo_din,
  output logic                     b_fifo_wren,
  output logic                     b_fifo_del,
  input  logic                     b_fifo_afull,
`ifdef PORT_STATS_EN
  input  logic [3:0]               stats_sel,
  output logic [31:0]              stats_frames,
  output logic [31:0]              stats_errs,
`endif
  output st_e                      o_dbg_state
);

  localparam int PW = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;

  st_e                    r_state, w_state_nxt;
  logic [PW-1:0]          r_grant, r_ptr;
  logic [LEN_W-1:0]       r_cnt;
  logic                   r_sat;
  logic [HDR_BYTES*8-1:0] r_hdr;
  logic [7:0]             r_bdin;
  logic                   r_bwren, r_bdel, r_hwren;
  logic [127:0]           r_hdin;

  logic [PORT_NUM-1:0]    w_elig, w_gnt_oh;
  logic [PW-1:0]          w_gnt_idx, w_ptr_nxt;
  logic                   w_gnt_vld, w_start, w_pop, w_last, w_sat, w_err;
  logic [7:0]             w_byte;
  logic [LEN_W-1:0]       w_len;
  logic [HDR_BYTES*8-1:0] w_hdr;
  logic [127:0]           w_hdr_word;

  assign w_elig = in_frame_exist & ~in_empty;

  rr_arbiter #(.PORT_NUM(PORT_NUM)) u_rr (
    .i_req   (w_elig),
    .i_ptr   (r_ptr),
    .o_gnt   (w_gnt_oh),
    .o_valid (w_gnt_vld)
  );

  always_comb begin
    w_gnt_idx = '0;
    for (int k = 0; k < PORT_NUM; k++) begin
      if (w_gnt_oh[k]) w_gnt_idx = PW'(k);
    end
  end

  assign w_start   = w_gnt_vld && !h_fifo_full && !b_fifo_afull;
  assign w_byte    = in_dout[int'(r_grant)*8 +: 8];
  assign w_pop     = (r_state == READ) && !in_empty[r_grant];
  assign w_last    = w_pop && in_eod[r_grant];
  assign w_len     = (r_cnt == LEN_SAT) ? r_cnt : r_cnt + 1'b1;
  // A pop arriving with the counter already pinned means the length overflowed.
  assign w_sat     = r_sat || (r_cnt == LEN_SAT);
  assign w_err     = (w_len < LEN_W'(MIN_LEN)) || (w_len > LEN_W'(MAX_LEN)) || w_sat;
  assign w_ptr_nxt = (r_grant == PW'(PORT_NUM - 1)) ? '0 : r_grant + 1'b1;

  always_comb begin
    in_rden = '0;
    if (w_pop) in_rden[r_grant] = 1'b1;
  end

  always_comb begin
    w_hdr = r_hdr;
    for (int b = 0; b < HDR_BYTES; b++) begin
      if (r_cnt == LEN_W'(b)) w_hdr[(HDR_BYTES-1-b)*8 +: 8] = w_byte;
    end
  end

  always_comb begin
    w_hdr_word                  = '0;
    w_hdr_word[127:16]          = w_hdr;
    w_hdr_word[ERR_BIT]         = w_err;
    w_hdr_word[LEN_MSB:LEN_LSB] = w_len;
    w_hdr_word[PORT_MSB:0]      = (PORT_MSB+1)'(r_grant);
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_start) w_state_nxt = READ;
      READ:    if (w_last)  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_grant <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_sat   <= 1'b0;
      r_hdr   <= '0;
      r_bdin  <= '0;
      r_bwren <= 1'b0;
      r_bdel  <= 1'b0;
      r_hwren <= 1'b0;
      r_hdin  <= '0;
    end else begin
      r_bwren <= w_pop;
      r_bdel  <= w_last;
      r_hwren <= w_last;
      if (w_pop) begin
        r_bdin <= w_byte;
        r_cnt  <= w_len;
        r_hdr  <= w_hdr;
        r_sat  <= w_sat;
      end
      if (w_last) begin
        r_hdin <= w_hdr_word;
        r_ptr  <= w_ptr_nxt;
      end
      if ((r_state == IDLE) && w_start) begin
        r_grant <= w_gnt_idx;
        r_cnt   <= '0;
        r_hdr   <= '0;
        r_sat   <= 1'b0;
      end
    end
  end

  assign b_fifo_din  = r_bdin;
  assign b_fifo_wren = r_bwren;
  assign b_fifo_del  = r_bdel;
  assign h_fifo_wren = r_hwren;
  assign h_fifo_din  = HEADER_DWIDTH'(r_hdin);
  assign o_dbg_state = r_state;

`ifdef PORT_STATS_EN
  logic [31:0] r_frames [PORT_NUM];
  logic [31:0] r_errs   [PORT_NUM];

  // r_grant still names the finished frame's port during the header-write cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < PORT_NUM; k++) begin
        r_frames[k] <= '0;
        r_errs[k]   <= '0;
      end
    end else if (r_hwren) begin
      r_frames[r_grant] <= r_frames[r_grant] + 1'b1;
      if (r_hdin[ERR_BIT]) r_errs[r_grant] <= r_errs[r_grant] + 1'b1;
    end
  end

  always_comb begin
    stats_frames = '0;
    stats_errs   = '0;
    for (int k = 0; k < PORT_NUM; k++) begin
      if (stats_sel == 4'(k)) begin
        stats_frames = r_frames[k];
        stats_errs   = r_errs[k];
      end
    end
  end
`endif

endmodule
